// File: rtl/tone_seq_pkg.sv
// Shared types and defaults for the tone sequencer: FSM state encoding,
// default word widths and the prescaler width helper.
package tone_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LOAD  = 2'd2,
    ST_PLAY  = 2'd3
  } state_e;

  localparam int unsigned FREQ_W_DEF = 32;
  localparam int unsigned DUR_W_DEF  = 16;

  // Prescaler needs at least one bit even when TICK_DIV is 1.
  function automatic int unsigned presc_width(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/tone_seq_mem.sv
// Tone table: DEPTH x W storage with one write port and a registered read port.
// Contents are not reset.
module tone_seq_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 48,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [W-1:0]  i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [W-1:0]  o_rd_data
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rd_q;

  // Single write port plus synchronous read
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem_q[i_wr_addr] <= i_wr_data;
    end
    rd_q <= mem_q[i_rd_addr];
  end

  assign o_rd_data = rd_q;

endmodule

// File: rtl/tone_sequencer.sv
// Steps through a (freq, duration) table and drives the fm freq word.
// Optional feature macro: TONE_SEQUENCER_LOOP_EN (adds i_loop for endless playback).
module tone_sequencer
  import tone_seq_pkg::*;
#(
  parameter int unsigned FREQ_W   = FREQ_W_DEF,
  parameter int unsigned DUR_W    = DUR_W_DEF,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned TICK_DIV = 50000,
  localparam int unsigned ADDR_W  = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [FREQ_W-1:0] i_wr_freq,
  input  logic [DUR_W-1:0]  i_wr_dur,
  input  logic              i_start,
  input  logic              i_stop,
`ifdef TONE_SEQUENCER_LOOP_EN
  input  logic              i_loop,
`endif
  output logic [FREQ_W-1:0] o_freq,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_idx,
  output logic              o_done
);

  localparam int unsigned PRESC_W = presc_width(TICK_DIV);
  localparam logic [PRESC_W-1:0] PRESC_RELOAD = PRESC_W'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0]  ADDR_LAST    = ADDR_W'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [DUR_W-1:0]    dur_cnt_q, dur_cnt_d;
  logic [FREQ_W-1:0]   freq_q, freq_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  logic [FREQ_W+DUR_W-1:0] rd_data_s;
  logic [FREQ_W-1:0]       ent_freq_s;
  logic [DUR_W-1:0]        ent_dur_s;
  logic                    loop_s;
  logic                    tick_end_s;
  logic                    last_tick_s;
  logic                    we_s;

`ifdef TONE_SEQUENCER_LOOP_EN
  assign loop_s = i_loop;
`else
  assign loop_s = 1'b0;
`endif

  // The table is frozen while a sequence plays
  assign we_s        = i_wr_en && (state_q == ST_IDLE);
  assign ent_freq_s  = rd_data_s[FREQ_W+DUR_W-1:DUR_W];
  assign ent_dur_s   = rd_data_s[DUR_W-1:0];
  assign tick_end_s  = (presc_q == {PRESC_W{1'b0}});
  assign last_tick_s = tick_end_s && (dur_cnt_q == DUR_W'(1));

  tone_seq_mem #(
    .DEPTH (DEPTH),
    .W     (FREQ_W + DUR_W)
  ) u_mem (
    .i_clk     (i_clk),
    .i_wr_en   (we_s),
    .i_wr_addr (i_wr_addr),
    .i_wr_data ({i_wr_freq, i_wr_dur}),
    .i_rd_addr (addr_q),
    .o_rd_data (rd_data_s)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= {ADDR_W{1'b0}};
      presc_q   <= {PRESC_W{1'b0}};
      dur_cnt_q <= {DUR_W{1'b0}};
      freq_q    <= {FREQ_W{1'b0}};
      idx_q     <= {ADDR_W{1'b0}};
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      presc_q   <= presc_d;
      dur_cnt_q <= dur_cnt_d;
      freq_q    <= freq_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state logic; stop overrides everything outside IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start && !i_stop) state_d = ST_FETCH;
        else                    state_d = ST_IDLE;
      end
      ST_FETCH: begin
        if (i_stop) state_d = ST_IDLE;
        else        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (i_stop)                          state_d = ST_IDLE;
        else if (ent_dur_s == {DUR_W{1'b0}}) state_d = loop_s ? ST_FETCH : ST_IDLE;
        else                                 state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (i_stop)                                        state_d = ST_IDLE;
        else if (last_tick_s && addr_q == ADDR_LAST && !loop_s) state_d = ST_IDLE;
        else if (last_tick_s)                              state_d = ST_FETCH;
        else                                               state_d = ST_PLAY;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    addr_d    = addr_q;
    presc_d   = presc_q;
    dur_cnt_d = dur_cnt_q;
    freq_d    = freq_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    busy_d    = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        freq_d = {FREQ_W{1'b0}};
        if (state_d == ST_FETCH) addr_d = {ADDR_W{1'b0}};
        else                     addr_d = addr_q;
      end
      ST_FETCH: begin
        if (i_stop) begin
          freq_d = {FREQ_W{1'b0}};
          idx_d  = {ADDR_W{1'b0}};
        end else begin
          freq_d = freq_q;
        end
      end
      ST_LOAD: begin
        if (i_stop) begin
          freq_d = {FREQ_W{1'b0}};
          idx_d  = {ADDR_W{1'b0}};
        end else if (ent_dur_s == {DUR_W{1'b0}}) begin
          if (loop_s) begin
            addr_d = {ADDR_W{1'b0}};
          end else begin
            done_d = 1'b1;
            freq_d = {FREQ_W{1'b0}};
          end
        end else begin
          freq_d    = ent_freq_s;
          idx_d     = addr_q;
          dur_cnt_d = ent_dur_s;
          presc_d   = PRESC_RELOAD;
        end
      end
      ST_PLAY: begin
        if (i_stop) begin
          freq_d = {FREQ_W{1'b0}};
          idx_d  = {ADDR_W{1'b0}};
        end else begin
          if (tick_end_s) begin
            presc_d   = PRESC_RELOAD;
            dur_cnt_d = dur_cnt_q - DUR_W'(1);
          end else begin
            presc_d   = presc_q - PRESC_W'(1);
          end
          if (last_tick_s && addr_q == ADDR_LAST && !loop_s) begin
            done_d = 1'b1;
            freq_d = {FREQ_W{1'b0}};
          end else if (last_tick_s) begin
            addr_d = addr_q + ADDR_W'(1);
          end else begin
            addr_d = addr_q;
          end
        end
      end
      default: begin
        freq_d = {FREQ_W{1'b0}};
      end
    endcase
  end

  assign o_freq = freq_q;
  assign o_busy = busy_q;
  assign o_idx  = idx_q;
  assign o_done = done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Randomized self-checking bench for tone_sequencer (DEPTH=8, TICK_DIV=4).
// The expected per-cycle trace is derived from the table contents and timing rules.
module tb_tone_sequencer;

  localparam int DEPTH = 8;
  localparam int TD    = 4;

  typedef struct packed {
    logic [31:0] f;
    logic        b;
    logic        dn;
    logic [2:0]  ix;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = 3'd0;
  logic [31:0] wr_freq = 32'd0;
  logic [15:0] wr_dur = 16'd0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop = 1'b0;
  logic [31:0] o_freq;
  logic        o_busy;
  logic [2:0]  o_idx;
  logic        o_done;

  int vecs = 0;
  int fails = 0;

  logic [31:0] tbl_f [DEPTH];
  logic [15:0] tbl_d [DEPTH];
  logic [2:0]  m_idx = 3'd0;
  exp_t        exp_q [$];

  tone_sequencer #(.FREQ_W(32), .DUR_W(16), .DEPTH(DEPTH), .TICK_DIV(TD)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_freq (wr_freq),
    .i_wr_dur  (wr_dur),
    .i_start   (start),
    .i_stop    (stop),
`ifdef TONE_SEQUENCER_LOOP_EN
    .i_loop    (loop),
`endif
    .o_freq    (o_freq),
    .o_busy    (o_busy),
    .o_idx     (o_idx),
    .o_done    (o_done)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [31:0] f, input logic b, input logic dn, input logic [2:0] ix);
    exp_t e;
    e.f = f; e.b = b; e.dn = dn; e.ix = ix;
    return e;
  endfunction

  // Expected trace, one entry per cycle starting the cycle after start is sampled.
  task automatic build_expect();
    int n;
    exp_q.delete();
    exp_q.push_back(mk(32'd0, 1'b1, 1'b0, m_idx));
    exp_q.push_back(mk(32'd0, 1'b1, 1'b0, m_idx));
    for (int a = 0; a < DEPTH; a++) begin
      if (tbl_d[a] == 16'd0) begin
        exp_q.push_back(mk(32'd0, 1'b0, 1'b1, m_idx));
        break;
      end
      m_idx = 3'(a);
      n = int'(tbl_d[a]) * TD;
      if (a == DEPTH - 1) begin
        for (int k = 0; k < n; k++) exp_q.push_back(mk(tbl_f[a], 1'b1, 1'b0, m_idx));
        exp_q.push_back(mk(32'd0, 1'b0, 1'b1, m_idx));
        break;
      end
      for (int k = 0; k < n + 2; k++) exp_q.push_back(mk(tbl_f[a], 1'b1, 1'b0, m_idx));
    end
  endtask

  // Called at a negedge; leaves the bench at the following negedge.
  task automatic wr(input int a, input logic [31:0] f, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = 3'(a); wr_freq = f; wr_dur = d;
    tbl_f[a] = f; tbl_d[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic check_cycle(input string name, input exp_t e);
    vecs++;
    if (o_freq !== e.f || o_busy !== e.b || o_done !== e.dn || o_idx !== e.ix) begin
      fails++;
      $display("FAIL %s @%0t: got f=%0d busy=%0b done=%0b idx=%0d, want f=%0d busy=%0b done=%0b idx=%0d",
               name, $time, o_freq, o_busy, o_done, o_idx, e.f, e.b, e.dn, e.ix);
    end
  endtask

  // Plays the loaded table; disturb injects a write and a start while busy.
  task automatic check_run(input string name, input bit disturb);
    build_expect();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      check_cycle(name, exp_q[k]);
      if (disturb && k == 3) begin
        wr_en = 1'b1; wr_addr = 3'd1; wr_freq = $urandom | 32'h1; wr_dur = 16'd7;
        start = 1'b1;
      end else begin
        wr_en = 1'b0; start = 1'b0;
      end
      @(negedge clk);
    end
    wr_en = 1'b0; start = 1'b0;
    check_cycle({name, "_idle"}, mk(32'd0, 1'b0, 1'b0, m_idx));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    check_cycle("reset", mk(32'd0, 1'b0, 1'b0, 3'd0));
    rst = 1'b0;
    @(negedge clk);
    check_cycle("reset_release", mk(32'd0, 1'b0, 1'b0, 3'd0));
    m_idx = 3'd0;
  endtask

  task automatic test_basic();
    wr(0, 32'd10000, 16'd3);
    wr(1, 32'd5000, 16'd2);
    wr(2, 32'd0, 16'd0);
    check_run("basic", 1'b0);
  endtask

  task automatic test_full_table();
    for (int a = 0; a < DEPTH; a++) wr(a, 32'd100 + 32'($urandom_range(0, 999)), 16'd1);
    check_run("full_table", 1'b0);
  endtask

  task automatic test_rest();
    wr(0, 32'd7000, 16'd1);
    wr(1, 32'd0, 16'd2);
    wr(2, 32'd3000, 16'd1);
    wr(3, 32'd0, 16'd0);
    check_run("rest", 1'b0);
  endtask

  task automatic test_write_while_busy();
    wr(0, 32'd1111, 16'd1);
    wr(1, 32'd2222, 16'd2);
    wr(2, 32'd3333, 16'd1);
    wr(3, 32'd0, 16'd0);
    check_run("wr_busy", 1'b1);
    check_run("wr_busy_replay", 1'b0);
  endtask

  task automatic test_stop();
    wr(0, 32'd4000, 16'd2);
    wr(1, 32'd4500, 16'd2);
    wr(2, 32'd4800, 16'd1);
    wr(3, 32'd0, 16'd0);
    build_expect();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 14; k++) begin
      check_cycle("stop_pre", exp_q[k]);
      if (k == 13) stop = 1'b1;
      @(negedge clk);
    end
    stop = 1'b0;
    m_idx = 3'd0;
    for (int k = 0; k < 5; k++) begin
      check_cycle("stop_post", mk(32'd0, 1'b0, 1'b0, 3'd0));
      @(negedge clk);
    end
  endtask

  task automatic test_stop_wins();
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_cycle("stop_wins", mk(32'd0, 1'b0, 1'b0, m_idx));
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    int mpos;
    for (int it = 0; it < 12; it++) begin
      mpos = $urandom_range(0, DEPTH);
      for (int a = 0; a < DEPTH; a++) begin
        if (a == mpos) wr(a, $urandom, 16'd0);
        else wr(a, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom, 16'($urandom_range(1, 3)));
      end
      check_run("random", 1'b0);
    end
  endtask

  task automatic test_async_reset();
    wr(0, 32'd9000, 16'd3);
    wr(1, 32'd0, 16'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    vecs++;
    if (o_freq !== 32'd9000) begin
      fails++;
      $display("FAIL async_reset_pre: got f=%0d want f=9000", o_freq);
    end
    #2 rst = 1'b1;
    #1;
    check_cycle("async_reset", mk(32'd0, 1'b0, 1'b0, 3'd0));
    @(negedge clk);
    rst = 1'b0;
    m_idx = 3'd0;
    @(negedge clk);
    check_cycle("async_reset_after", mk(32'd0, 1'b0, 1'b0, 3'd0));
  endtask

  task automatic test_loop();
`ifdef TONE_SEQUENCER_LOOP_EN
    wr(0, 32'd2500, 16'd1);
    wr(1, 32'd0, 16'd0);
    loop = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      check_cycle("loop", mk((k < 2) ? 32'd0 : 32'd2500, 1'b1, 1'b0, 3'd0));
      @(negedge clk);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    loop = 1'b0;
    m_idx = 3'd0;
    check_cycle("loop_stop", mk(32'd0, 1'b0, 1'b0, 3'd0));
`else
    loop = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_table();
    test_rest();
    test_write_while_busy();
    test_stop();
    test_stop_wins();
    test_random();
    test_async_reset();
    test_loop();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
